// File: rtl/pc_fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit_if                                                |
// | Purpose  : Bundles the control/target inputs and the fetch outputs of the  |
// |            program-counter sequencer into one interface.                   |
// | Ports    : trigger, iStall, iPCSrc[1:0], iImmExt, iALUResult, iHalt        |
// |            (into the sequencer); oPC, oPCPlus4, oValid, oState[1:0],       |
// |            oMisaligned, oRetired (out of the sequencer).                   |
// |            master = control-unit side, slave = sequencer side.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  trigger;
  logic                  iStall;
  logic [1:0]            iPCSrc;
  logic [ADDR_WIDTH-1:0] iImmExt;
  logic [ADDR_WIDTH-1:0] iALUResult;
  logic                  iHalt;
  logic [ADDR_WIDTH-1:0] oPC;
  logic [ADDR_WIDTH-1:0] oPCPlus4;
  logic                  oValid;
  logic [1:0]            oState;
  logic                  oMisaligned;
  logic [CNT_WIDTH-1:0]  oRetired;

  modport master (
    output trigger, iStall, iPCSrc, iImmExt, iALUResult, iHalt,
    input  oPC, oPCPlus4, oValid, oState, oMisaligned, oRetired
  );

  modport slave (
    input  trigger, iStall, iPCSrc, iImmExt, iALUResult, iHalt,
    output oPC, oPCPlus4, oValid, oState, oMisaligned, oRetired
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit                                                   |
// | Purpose  : Program-counter / fetch sequencer. IDLE/RUN/HALT/FAULT state    |
// |            machine started by trigger, with stall, PC+4 / branch-JAL /     |
// |            JALR target selection, halt detection (iHalt or "j ."),         |
// |            misaligned-target fault and a saturating retired counter.      |
// | Ports    : clk, rst (synchronous, active-high)                             |
// |            bus (pc_fetch_unit_if.slave): trigger, iStall, iPCSrc, iImmExt, |
// |            iALUResult, iHalt in; oPC, oPCPlus4, oValid, oState,            |
// |            oMisaligned, oRetired out.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH        = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = '0,
  parameter int                    CNT_WIDTH         = 32,
  parameter bit                    HALT_ON_SELF_LOOP = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pc_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] JALR_MASK   = ~ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  RETIRED_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  RETIRED_ONE = CNT_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_WIDTH-1:0]  retired;
  logic                  misaligned;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [CNT_WIDTH-1:0]  retired_inc;
  logic                  self_loop;
  logic                  next_misaligned;

  assign pc_plus4 = pc + PC_STEP;

  // Target selection; encoding 11 falls back to sequential fetch.
  always_comb begin
    next_pc = pc_plus4;
    case (bus.iPCSrc)
      2'b01:   next_pc = pc + bus.iImmExt;
      2'b10:   next_pc = bus.iALUResult & JALR_MASK;
      default: next_pc = pc_plus4;
    endcase
  end

  assign next_misaligned = (next_pc[1:0] != 2'b00);

  // Counter sticks at all-ones instead of wrapping.
  assign retired_inc = (retired == RETIRED_MAX) ? retired : (retired + RETIRED_ONE);

  // A taken target equal to the current PC ("j .") can be treated as a halt.
  if (HALT_ON_SELF_LOOP) begin : g_self_loop_halt
    assign self_loop = (next_pc == pc);
  end else begin : g_self_loop_off
    assign self_loop = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_VECTOR;
      retired    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.trigger) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A stalled cycle freezes everything; halt/target inputs are not looked at.
          if (!bus.iStall) begin
            if (next_misaligned) begin
              // Faulting instruction does not retire; PC keeps pointing at it.
              state      <= ST_FAULT;
              misaligned <= 1'b1;
            end else if (bus.iHalt || self_loop) begin
              state   <= ST_HALT;
              retired <= retired_inc;
            end else begin
              pc      <= next_pc;
              retired <= retired_inc;
            end
          end
        end
        ST_HALT: begin
          if (bus.trigger) begin
            state   <= ST_RUN;
            pc      <= RESET_VECTOR;
            retired <= '0;
          end
        end
        ST_FAULT: begin
          // Absorbing: only rst leaves this state.
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oPC         = pc;
  assign bus.oPCPlus4    = pc_plus4;
  assign bus.oValid      = (state == ST_RUN) && !bus.iStall;
  assign bus.oState      = state;
  assign bus.oMisaligned = misaligned;
  assign bus.oRetired    = retired;

endmodule

`default_nettype wire
